// File: rtl/video_scanout.sv
// video_scanout: 640x480@60 raster generator that reads a 160x144 2-bit
// frame buffer with x3 integer scaling, centred, and emits registered
// sync / data-enable / RGB444 for a downstream VGA/HDMI encoder.
module video_scanout #(
    parameter logic [11:0] PAL0   = 12'hFFF,
    parameter logic [11:0] PAL1   = 12'hAAA,
    parameter logic [11:0] PAL2   = 12'h555,
    parameter logic [11:0] PAL3   = 12'h000,
    parameter logic [11:0] BORDER = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    output logic [14:0] addrb,
    output logic        enb,
    input  logic [1:0]  doutb,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    logic [9:0]  h, v;
    logic [1:0]  x_sub, y_sub;
    logic [7:0]  fb_x;
    logic [14:0] row_base;

    logic h_last, v_last, win_h, win_v, win, act, hs_act, vs_act, at_origin;

    // Stage tags; sync tags are kept active-high so a cleared pipe means "inactive"
    logic win_s1, de_s1, hs_s1, vs_s1, fs_s1;
    logic win_s2, de_s2, hs_s2, vs_s2, fs_s2;
    logic [11:0] shade_rgb;

    // Decode of the current counter position
    always_comb begin
        h_last    = (h == 10'd799);
        v_last    = (v == 10'd524);
        win_h     = (h >= 10'd80) && (h < 10'd560);
        win_v     = (v >= 10'd24) && (v < 10'd456);
        win       = win_h && win_v;
        act       = (h < 10'd640) && (v < 10'd480);
        hs_act    = (h >= 10'd656) && (h < 10'd752);
        vs_act    = (v >= 10'd490) && (v < 10'd492);
        at_origin = (h == 10'd0) && (v == 10'd0);
    end

    // Raster counters: h wraps into v, v wraps at end of frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Horizontal x3 scaling: fb_x advances every third window pixel, restarts each line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_sub <= '0;
            fb_x  <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                x_sub <= '0;
                fb_x  <= '0;
            end else if (win_h) begin
                if (x_sub == 2'd2) begin
                    x_sub <= '0;
                    fb_x  <= fb_x + 8'd1;
                end else begin
                    x_sub <= x_sub + 2'd1;
                end
            end
        end
    end

    // Vertical x3 scaling: row_base (= fb_y*160) steps every third window line,
    // cleared at frame wrap so the last line of a frame never bumps it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_sub    <= '0;
            row_base <= '0;
        end else if (pix_ce && h_last) begin
            if (v_last) begin
                y_sub    <= '0;
                row_base <= '0;
            end else if (win_v) begin
                if (y_sub == 2'd2) begin
                    y_sub    <= '0;
                    row_base <= row_base + 15'd160;
                end else begin
                    y_sub <= y_sub + 2'd1;
                end
            end
        end
    end

    // Stage 1: read address plus position tags; address only loaded inside the window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addrb  <= '0;
            win_s1 <= 1'b0;
            de_s1  <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            fs_s1  <= 1'b0;
        end else if (pix_ce) begin
            addrb  <= win ? (row_base + {7'd0, fb_x}) : 15'd0;
            win_s1 <= win;
            de_s1  <= act;
            hs_s1  <= hs_act;
            vs_s1  <= vs_act;
            fs_s1  <= at_origin;
        end
    end

    // The buffer samples addrb on the pix_ce edge following stage 1
    assign enb = pix_ce & win_s1;

    // Stage 2: tags wait out the buffer read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_s2 <= 1'b0;
            de_s2  <= 1'b0;
            hs_s2  <= 1'b0;
            vs_s2  <= 1'b0;
            fs_s2  <= 1'b0;
        end else if (pix_ce) begin
            win_s2 <= win_s1;
            de_s2  <= de_s1;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
            fs_s2  <= fs_s1;
        end
    end

    // Fixed 4-entry palette
    always_comb begin
        shade_rgb = PAL0;
        case (doutb)
            2'd1:    shade_rgb = PAL1;
            2'd2:    shade_rgb = PAL2;
            2'd3:    shade_rgb = PAL3;
            default: shade_rgb = PAL0;
        endcase
    end

    // Output stage: doutb is stable here because enb drops on non-pix_ce clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            hsync_n     <= ~hs_s2;
            vsync_n     <= ~vs_s2;
            de          <= de_s2;
            rgb         <= !de_s2 ? 12'h000 : (win_s2 ? shade_rgb : BORDER);
            frame_start <= fs_s2;
        end
    end

endmodule

// File: tb/tb_video_scanout.sv
// Scoreboard bench for video_scanout: a reference raster model pushes the
// expected output word per pix_ce edge, popped three edges later.
module tb_video_scanout;

    localparam logic [11:0] BORDER_C = 12'h123;
    localparam logic [15:0] IDLE     = 16'hC000; // hs_n=1 vs_n=1 de=0 fs=0 rgb=0

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic [14:0] addrb;
    logic        enb;
    logic [1:0]  doutb = 2'b00;
    logic        hsync_n, vsync_n, de, frame_start;
    logic [11:0] rgb;

    logic [1:0]  mem [0:23039];

    int checks = 0;
    int failures = 0;

    logic [15:0] sbq[$];
    int          pq[$];
    logic [15:0] last_exp;
    int mh, mv;            // model counter position
    int rh, rv;            // position most recently registered into stage 1
    bit rwin;
    int oh, ov;            // position shown on the outputs (-1 during pipeline fill)

    video_scanout #(.BORDER(BORDER_C)) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
        .addrb(addrb), .enb(enb), .doutb(doutb),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .rgb(rgb),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame buffer read port: 1-clk registered read, holds while enb=0
    always @(posedge clk) begin
        if (enb && addrb < 15'd23040) doutb <= mem[addrb];
    end

    function automatic logic [11:0] pal(input logic [1:0] s);
        case (s)
            2'd0: return 12'hFFF;
            2'd1: return 12'hAAA;
            2'd2: return 12'h555;
            default: return 12'h000;
        endcase
    endfunction

    function automatic bit in_win(input int hh, input int vv);
        return hh >= 80 && hh < 560 && vv >= 24 && vv < 456;
    endfunction

    function automatic int exp_addr(input int hh, input int vv);
        return ((vv - 24) / 3) * 160 + (hh - 80) / 3;
    endfunction

    function automatic logic [15:0] expect_at(input int hh, input int vv);
        logic [11:0] c;
        bit d;
        d = hh < 640 && vv < 480;
        if (!d) c = 12'h000;
        else if (in_win(hh, vv)) c = pal(mem[exp_addr(hh, vv)]);
        else c = BORDER_C;
        return {~(hh >= 656 && hh < 752), ~(vv >= 490 && vv < 492), d, (hh == 0 && vv == 0), c};
    endfunction

    task automatic resync(input int vv);
        sbq.delete();
        pq.delete();
        sbq.push_back(IDLE); pq.push_back(-1);
        sbq.push_back(IDLE); pq.push_back(-1);
        last_exp = IDLE;
        mh = 0; mv = vv; rh = -1; rv = -1; rwin = 0; oh = -1; ov = -1;
    endtask

    // One clk with pix_ce=ce; all per-cycle comparisons happen here
    task automatic tick(input bit ce);
        logic [15:0] got, exp;
        int p;
        pix_ce = ce;
        #1;
        checks++;
        if (enb !== (ce & rwin) || (enb === 1'b1 && addrb >= 15'd23040)) begin
            failures++;
            $display("FAIL enb got=%b addr=%0d exp=%b", enb, addrb, ce & rwin);
        end
        @(posedge clk);
        #1;
        got = {hsync_n, vsync_n, de, frame_start, rgb};
        if (ce) begin
            sbq.push_back(expect_at(mh, mv));
            pq.push_back(mh * 1024 + mv);
            rh = mh; rv = mv; rwin = in_win(mh, mv);
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 524) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            if (rwin) begin
                checks++;
                if (addrb !== 15'(exp_addr(rh, rv))) begin
                    failures++;
                    $display("FAIL addrb at (%0d,%0d) got=%0d exp=%0d", rh, rv, addrb, exp_addr(rh, rv));
                end
            end
            if (sbq.size() >= 3) begin
                exp = sbq.pop_front();
                p = pq.pop_front();
                oh = (p < 0) ? -1 : p / 1024;
                ov = (p < 0) ? -1 : p % 1024;
                last_exp = exp;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL pixel (%0d,%0d) got=%h exp=%h", oh, ov, got, exp);
                end
            end
        end else begin
            checks++;
            if (got !== last_exp) begin
                failures++;
                $display("FAIL hold got=%h exp=%h", got, last_exp);
            end
        end
    endtask

    // Reset, then place the vertical state at line tv (h=0) with pix_ce held low
    task automatic jump(input int tv);
        logic [9:0]  fv;
        logic [1:0]  fy;
        logic [14:0] fr;
        fv = 10'(tv);
        fy = (tv >= 24 && tv < 456) ? 2'((tv - 24) % 3) : 2'd0;
        fr = (tv < 24) ? 15'd0 : (tv >= 456) ? 15'd23040 : 15'(((tv - 24) / 3) * 160);
        pix_ce = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        force dut.v = fv;
        force dut.y_sub = fy;
        force dut.row_base = fr;
        @(posedge clk); #1;
        release dut.v;
        release dut.y_sub;
        release dut.row_base;
        resync(tv);
    endtask

    task automatic test_reset();
        jump(100);
        repeat (300) tick(1);
        pix_ce = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({addrb, enb, hsync_n, vsync_n, de, rgb, frame_start} !== {15'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got addr=%0d enb=%b hs=%b vs=%b de=%b rgb=%h fs=%b exp 0,0,1,1,0,000,0",
                     addrb, enb, hsync_n, vsync_n, de, rgb, frame_start);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        resync(0);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            checks++;
            if (frame_start !== (i == 3) || de !== (i == 3)) begin
                failures++;
                $display("FAIL reset_first_pixel edge %0d got fs=%b de=%b exp=%b", i, frame_start, de, i == 3);
            end
        end
        repeat (50) tick(1);
    endtask

    task automatic test_window_start_palette();
        logic [11:0] seen [0:11];
        int a6 [0:5];
        int a4 [0:3];
        a6 = '{0, 0, 0, 1, 1, 1};
        a4 = '{0, 0, 0, 160};
        jump(24);
        for (int i = 0; i < 3 * 800 + 100; i++) begin
            tick(1);
            if (rv == 24 && rh >= 80 && rh <= 85) begin
                checks++;
                if (addrb !== 15'(a6[rh - 80])) begin
                    failures++;
                    $display("FAIL win_start_addr h=%0d got=%0d exp=%0d", rh, addrb, a6[rh - 80]);
                end
            end
            if (rh == 80 && rv >= 24 && rv <= 27) begin
                checks++;
                if (addrb !== 15'(a4[rv - 24])) begin
                    failures++;
                    $display("FAIL line_start_addr v=%0d got=%0d exp=%0d", rv, addrb, a4[rv - 24]);
                end
            end
            if (ov == 24 && oh >= 80 && oh < 92) seen[oh - 80] = de ? rgb : 12'hBAD;
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seen[k] !== pal(2'(k / 3))) begin
                failures++;
                $display("FAIL palette px %0d got=%h exp=%h", k, seen[k], pal(2'(k / 3)));
            end
        end
    endtask

    task automatic test_window_end();
        logic [14:0] a_end;
        logic [11:0] c_border;
        a_end = '0;
        c_border = '0;
        jump(453);
        for (int i = 0; i < 1603; i++) begin
            tick(1);
            if (rh == 557 && rv == 453) a_end = addrb;
            if (oh == 600 && ov == 453) c_border = rgb;
            if (rh == 560 && rv == 453) begin
                pix_ce = 1'b1;
                #1;
                checks++;
                if (enb !== 1'b0) begin
                    failures++;
                    $display("FAIL win_end_enb got=%b exp=0", enb);
                end
            end
        end
        checks++;
        if (a_end !== 15'd23039) begin
            failures++;
            $display("FAIL win_end_addr got=%0d exp=23039", a_end);
        end
        checks++;
        if (c_border !== BORDER_C) begin
            failures++;
            $display("FAIL border got=%h exp=%h", c_border, BORDER_C);
        end
    endtask

    task automatic test_sync();
        int hlow, vlow, first_h;
        hlow = 0; vlow = 0; first_h = -1;
        jump(489);
        for (int i = 1; i <= 2403; i++) begin
            tick(1);
            if (i > 3) begin
                if (hsync_n === 1'b0) hlow++;
                if (vsync_n === 1'b0) vlow++;
                if (hsync_n === 1'b0 && first_h < 0) first_h = i;
            end
        end
        checks++;
        if (hlow != 288) begin failures++; $display("FAIL hsync_len got=%0d exp=288", hlow); end
        checks++;
        if (vlow != 1600) begin failures++; $display("FAIL vsync_len got=%0d exp=1600", vlow); end
        checks++;
        if (first_h != 659) begin failures++; $display("FAIL hsync_start got=%0d exp=659", first_h); end
    endtask

    task automatic test_frame_wrap();
        int first_fs, n_fs;
        first_fs = -1; n_fs = 0;
        jump(523);
        for (int i = 1; i <= 1700; i++) begin
            tick(1);
            if (frame_start === 1'b1) begin
                n_fs++;
                if (first_fs < 0) first_fs = i;
            end
        end
        checks++;
        if (first_fs != 1603 || n_fs != 1) begin
            failures++;
            $display("FAIL frame_wrap got first=%0d count=%0d exp first=1603 count=1", first_fs, n_fs);
        end
    endtask

    task automatic test_stall();
        jump(24);
        for (int i = 0; i < 900; i++) begin
            tick(1);
            repeat ($urandom_range(3, 5)) tick(0);
        end
    endtask

    initial begin
        for (int i = 0; i < 23040; i++) mem[i] = 2'($urandom_range(0, 3));
        mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3;
        resync(0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_window_start_palette();
        test_window_end();
        test_sync();
        test_frame_wrap();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
